// File: rtl/pkg1.sv
// First-field payload type produced by the field-generator stage.
package pkg1;
    typedef struct packed {
        logic [7:0] first;
    } struct1;
endpackage

// File: rtl/pkg2.sv
// Second-field payload type produced by the field-generator stage.
package pkg2;
    typedef struct packed {
        logic [6:0] second;
    } struct1;
endpackage

// File: rtl/sfs_pkg.sv
// Shared types for the struct frame serializer: third field, captured record, FSM states.
package sfs_pkg;
    localparam int unsigned REC_W  = 21;
    localparam int unsigned BYTE_W = 8;

    typedef struct packed {
        logic [5:0] third;
    } field3_t;

    // Both upstream types are named struct1; package scope keeps them distinct.
    typedef struct packed {
        pkg1::struct1 f1;
        pkg2::struct1 f2;
        field3_t      f3;
    } record_t;

    typedef enum logic [2:0] {
        IDLE,
        S_HDR,
        S_F1,
        S_F2,
        S_F3,
        S_SUM
    } state_t;
endpackage

// File: rtl/sfs_checksum.sv
// Combinational modulo-256 sum of the three captured record fields.
module sfs_checksum
    import sfs_pkg::*;
(
    input  record_t           rec_i,
    output logic [BYTE_W-1:0] sum_o
);

    // Low byte of the zero-extended sum equals the sum taken modulo 256.
    assign sum_o = rec_i.f1.first
                 + BYTE_W'(rec_i.f2.second)
                 + BYTE_W'(rec_i.f3.third);

endmodule

// File: rtl/struct_frame_serializer.sv
// Captures a {first, second, third} triple and emits it as a byte frame:
// header, three zero-extended field bytes and an optional checksum byte.
module struct_frame_serializer
    import sfs_pkg::*;
#(
    parameter logic [7:0]  HDR         = 8'hA5,
    parameter bit          CHECKSUM_EN = 1'b1,
    parameter int unsigned FRAME_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  pkg1::struct1           in_var1,
    input  pkg2::struct1           in_var2,
    input  field3_t                in_var3,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [BYTE_W-1:0]      out_data,
    output logic                   out_last,
    output logic [FRAME_CNT_W-1:0] frame_count,
    output logic                   busy
);

    state_t                 state_q, state_d;
    record_t                rec_q, rec_d;
    logic [FRAME_CNT_W-1:0] cnt_q, cnt_d;
    logic                   live_q;

    logic [BYTE_W-1:0]      sum_c;
    logic [BYTE_W-1:0]      data_c;
    logic                   busy_c;
    logic                   last_c;
    logic                   ready_c;
    logic                   adv_c;

    if (CHECKSUM_EN) begin : g_sum
        sfs_checksum u_checksum (
            .rec_i (rec_q),
            .sum_o (sum_c)
        );
    end else begin : g_nosum
        assign sum_c = '0;
    end

    // State, capture register and frame counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rec_q   <= '0;
            cnt_q   <= '0;
            live_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rec_q   <= rec_d;
            cnt_q   <= cnt_d;
            live_q  <= 1'b1;
        end
    end

    // Next state, capture and byte selection.
    always_comb begin
        state_d = state_q;
        rec_d   = rec_q;
        cnt_d   = cnt_q;
        data_c  = '0;

        busy_c  = (state_q != IDLE);
        last_c  = CHECKSUM_EN ? (state_q == S_SUM) : (state_q == S_F3);
        adv_c   = busy_c && out_ready;
        ready_c = live_q && ((state_q == IDLE) || (last_c && out_ready));

        case (state_q)
            S_HDR: begin
                data_c = HDR;
                if (adv_c) state_d = S_F1;
            end
            S_F1: begin
                data_c = rec_q.f1.first;
                if (adv_c) state_d = S_F2;
            end
            S_F2: begin
                data_c = {1'b0, rec_q.f2.second};
                if (adv_c) state_d = S_F3;
            end
            S_F3: begin
                data_c = {2'b00, rec_q.f3.third};
                if (adv_c) state_d = CHECKSUM_EN ? S_SUM : IDLE;
            end
            S_SUM: begin
                data_c = sum_c;
                if (adv_c) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (adv_c && last_c) begin
            cnt_d = cnt_q + FRAME_CNT_W'(1);
        end

        // A new triple may land on the last-byte handshake, so no idle bubble.
        if (in_valid && ready_c) begin
            rec_d.f1 = in_var1;
            rec_d.f2 = in_var2;
            rec_d.f3 = in_var3;
            state_d  = S_HDR;
        end
    end

    assign in_ready    = ready_c;
    assign out_valid   = busy_c;
    assign busy        = busy_c;
    assign out_data    = data_c;
    assign out_last    = last_c;
    assign frame_count = cnt_q;

endmodule

// File: doc/struct_frame_serializer.md
Name: struct_frame_serializer

Overview:
- Consumes the three packed-struct outputs of the field-generator stage (8-bit first, 7-bit second, 6-bit third) through a valid/ready handshake.
- Serializes each captured triple into a byte-wide framed stream: header, three zero-extended field bytes, optional checksum.
- Sits directly downstream of the field generator and feeds byte-oriented consumers such as link or debug ports.

Parameters:
- HDR, 8'hA5, header byte emitted first in every frame.
- CHECKSUM_EN, 1, 1 appends a checksum byte (5-byte frame); 0 omits it (4-byte frame).
- FRAME_CNT_W, 16, width of the completed-frame counter.

Ports:
- clk  in  1  clock; all state on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  upstream triple valid.
- in_ready  out  1  block accepts a triple this cycle.
- in_var1  in  8  pkg1::struct1 (field first).
- in_var2  in  7  pkg2::struct1 (field second).
- in_var3  in  6  sfs_pkg::field3_t (field third).
- out_valid  out  1  out_data valid.
- out_ready  in  1  downstream accepts byte.
- out_data  out  8  serialized byte.
- out_last  out  1  marks the final byte of a frame.
- frame_count  out  FRAME_CNT_W  completed frames, modulo 2^FRAME_CNT_W.
- busy  out  1  a frame is in progress (state != IDLE).

Behaviour:
- Reset: one clock; reset is asynchronous and active-low (clk, rst_n).
  - While rst_n=0: state=IDLE, capture register=0, frame_count=0, out_valid=0, out_last=0, out_data=0, busy=0, in_ready=0.
  - in_ready is 1 from the first clk edge after rst_n deasserts.
- FSM states: IDLE, S_HDR, S_F1, S_F2, S_F3, S_SUM (S_SUM only when CHECKSUM_EN=1).
- Capture:
  - Accept happens when in_valid && in_ready.
  - On accept, register {var1, var2, var3} and go to S_HDR on the next edge.
  - Latency from accept to first out_valid: 1 cycle.
- Byte advance: each byte advances on out_valid && out_ready.
  - Order: S_HDR→S_F1→S_F2→S_F3→(S_SUM if CHECKSUM_EN)→IDLE.
  - Byte values:
    - S_HDR: out_data=HDR.
    - S_F1: out_data=first.
    - S_F2: out_data={1'b0,second}.
    - S_F3: out_data={2'b00,third}.
    - S_SUM: out_data=(first+second+third) mod 256, with operands zero-extended to 10 bits and the low 8 bits taken.
- out_valid = busy. out_data and out_last are functions of state and the capture register only; there is no combinational path from in_var* to outputs.
- Backpressure: while out_valid && !out_ready, out_data, out_last and state hold stable.
- out_last is 1 in S_SUM (CHECKSUM_EN=1) or in S_F3 (CHECKSUM_EN=0).
- in_ready = (state==IDLE) || (out_last && out_ready).
  - Back-to-back: an accept coinciding with the last-byte handshake jumps straight to S_HDR. No idle bubble between frames.
- frame_count increments by 1 on each last-byte handshake and wraps silently from all-ones to 0.
- in_valid with in_ready=0: no effect; upstream must hold its data (it is a constant producer, so this is always safe).
- Reset mid-frame: the partial frame is discarded with no out_last. The counter is not incremented for that frame; it returns to 0 with the rest of the state.

Decomposition:
- New package sfs_pkg:
  - typedef field3_t, a packed struct {logic [5:0] third}.
  - typedef record_t, a packed struct of {pkg1::struct1, pkg2::struct1, field3_t}, 21 bits.
  - enum state_t for the FSM states.
  - localparam REC_W=21.
- Reuse pkg1::struct1 and pkg2::struct1 as-is. The same typedef name in different packages must resolve by package scope.
- One sub-module, sfs_checksum: combinational 8-bit sum of record_t fields, instantiated only under CHECKSUM_EN.

Test Plan:
1. Basic frame. Inputs var1=255, var2=127, var3=63, out_ready=1, CHECKSUM_EN=1 → bytes A5,FF,7F,3F,BD; out_last only on BD; frame_count=1.
2. Backpressure. As in test 1, with out_ready=0 for 3 cycles during S_F2 → 7F holds for 4 cycles with no skip or duplicate; frame completes with BD.
3. Back-to-back. in_valid held high with 2 distinct triples (1,2,3 then 10,20,30) → A5,01,02,03,06,A5,0A,14,1E,3C on consecutive cycles with no gap; frame_count=2.
4. No-checksum build. CHECKSUM_EN=0 with 255,127,63 → A5,FF,7F,3F with out_last on 3F; in_ready high in the same cycle.
5. Counter wrap. FRAME_CNT_W=2, 5 frames → frame_count sequence 1,2,3,0,1.
6. Reset mid-frame. Assert rst_n=0 asynchronously during S_F1 → outputs clear immediately without a clock edge; after release, a new frame 0,0,0 emits A5,00,00,00,00; frame_count=1.
